// File: rtl/register_file_multiport_pkg.sv
// ---------------------------------------------------------------------------
// PkgRegisterFileMp
// Shared definitions for the multi-port register file:
//   - default parameter constants
//   - clear/run state encoding (enum plus legacy-compatible constants)
//   - helper for locating a port's slice inside a packed port vector
// ---------------------------------------------------------------------------
package PkgRegisterFileMp;

    localparam int DEFAULT_DATA_WIDTH      = 32;
    localparam int DEFAULT_NUM_REGS        = 16;
    localparam int DEFAULT_NUM_READ_PORTS  = 2;
    localparam int DEFAULT_NUM_WRITE_PORTS = 1;
    localparam int DEFAULT_ZERO_REG_EN     = 1;
    localparam int DEFAULT_BYPASS_EN       = 1;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } rf_state_e;

    localparam logic [0:0] STATE_CLEAR = ST_CLEAR;
    localparam logic [0:0] STATE_RUN   = ST_RUN;

    // Low bit position of port 'index' in a packed vector of 'width'-bit fields.
    function automatic int slice_lo(input int index, input int width);
        return index * width;
    endfunction

endpackage

// File: rtl/register_file_multiport_if.sv
// ---------------------------------------------------------------------------
// register_file_multiport_if
// Bus between a register-file user (master) and the register file (slave).
//   read_sel       packed read indices, port p at [p*SEL_WIDTH +: SEL_WIDTH]
//   read_data      packed asynchronous read data
//   write_en       per-port write enable
//   write_sel      packed write indices
//   write_data     packed write data
//   clear_req      request a full re-clear
//   busy           clear in progress
//   write_conflict registered same-target write indication
// ---------------------------------------------------------------------------
interface register_file_multiport_if
    import PkgRegisterFileMp::*;
#(
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int NUM_REGS        = DEFAULT_NUM_REGS,
    parameter int NUM_READ_PORTS  = DEFAULT_NUM_READ_PORTS,
    parameter int NUM_WRITE_PORTS = DEFAULT_NUM_WRITE_PORTS
);
    localparam int SEL_WIDTH = $clog2(NUM_REGS);

    logic [NUM_READ_PORTS*SEL_WIDTH-1:0]   read_sel;
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0]  read_data;
    logic [NUM_WRITE_PORTS-1:0]            write_en;
    logic [NUM_WRITE_PORTS*SEL_WIDTH-1:0]  write_sel;
    logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] write_data;
    logic                                  clear_req;
    logic                                  busy;
    logic                                  write_conflict;

    modport master (
        output read_sel, write_en, write_sel, write_data, clear_req,
        input  read_data, busy, write_conflict
    );

    modport slave (
        input  read_sel, write_en, write_sel, write_data, clear_req,
        output read_data, busy, write_conflict
    );

endinterface

// File: rtl/register_file_multiport_clear_ctrl.sv
// ---------------------------------------------------------------------------
// register_file_clear_ctrl
// Clear engine: after reset or a clear request it walks every register index
// once, issuing a zero-write strobe per cycle, then hands over to RUN.
//   clk        clock
//   rst        asynchronous active-high reset (enters CLEAR at index 0)
//   clear_req  restart the clear sequence (honoured only in RUN)
//   busy       high while clearing
//   clear_we   zero-write strobe for the storage array
//   clear_idx  register being zeroed this cycle
// ---------------------------------------------------------------------------
module register_file_clear_ctrl
    import PkgRegisterFileMp::*;
#(
    parameter int NUM_REGS  = DEFAULT_NUM_REGS,
    parameter int SEL_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_req,
    output logic                 busy,
    output logic                 clear_we,
    output logic [SEL_WIDTH-1:0] clear_idx
);
    localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_REGS - 1);

    logic [0:0]           state_q;
    logic [SEL_WIDTH-1:0] count_q;

    // The counter wraps back to 0 on the final clear write because NUM_REGS
    // is a power of two, so leaving CLEAR needs no explicit counter reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= STATE_CLEAR;
            count_q <= '0;
        end else if (state_q == STATE_CLEAR) begin
            count_q <= count_q + 1'b1;
            if (count_q == LAST_IDX) begin
                state_q <= STATE_RUN;
            end
        end else if (clear_req) begin
            state_q <= STATE_CLEAR;
            count_q <= '0;
        end
    end

    assign busy      = (state_q == STATE_CLEAR);
    assign clear_we  = busy;
    assign clear_idx = count_q;

endmodule

// File: rtl/register_file_multiport.sv
// ---------------------------------------------------------------------------
// register_file_multiport
// Parametrised register file with NUM_READ_PORTS asynchronous read ports and
// NUM_WRITE_PORTS synchronous write ports, optional hardwired-zero register 0,
// optional same-cycle write-to-read bypass and a sequential clear engine.
//   clk   clock, all state on the rising edge
//   rst   asynchronous active-high reset
//   bus   register_file_multiport_if.slave (read/write ports, clear_req,
//         busy, write_conflict)
// ---------------------------------------------------------------------------
module register_file_multiport
    import PkgRegisterFileMp::*;
#(
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int NUM_REGS        = DEFAULT_NUM_REGS,
    parameter int NUM_READ_PORTS  = DEFAULT_NUM_READ_PORTS,
    parameter int NUM_WRITE_PORTS = DEFAULT_NUM_WRITE_PORTS,
    parameter int ZERO_REG_EN     = DEFAULT_ZERO_REG_EN,
    parameter int BYPASS_EN       = DEFAULT_BYPASS_EN
) (
    input  logic                      clk,
    input  logic                      rst,
    register_file_multiport_if.slave  bus
);
    localparam int SEL_WIDTH = $clog2(NUM_REGS);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic                  busy;
    logic                  clear_we;
    logic [SEL_WIDTH-1:0]  clear_idx;

    logic [SEL_WIDTH-1:0]  wr_sel   [NUM_WRITE_PORTS];
    logic [DATA_WIDTH-1:0] wr_data  [NUM_WRITE_PORTS];
    logic                  write_eff[NUM_WRITE_PORTS];

    logic                  conflict_now;
    logic                  write_conflict_q;

    register_file_clear_ctrl #(
        .NUM_REGS  (NUM_REGS),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_clear_ctrl (
        .clk       (clk),
        .rst       (rst),
        .clear_req (bus.clear_req),
        .busy      (busy),
        .clear_we  (clear_we),
        .clear_idx (clear_idx)
    );

    // Unpack write ports and decide which ones actually land. Writes to the
    // hardwired zero register and all writes while clearing are dropped here,
    // so the conflict detector and bypass never see them.
    always_comb begin
        for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
            wr_sel[w]    = bus.write_sel[slice_lo(w, SEL_WIDTH) +: SEL_WIDTH];
            wr_data[w]   = bus.write_data[slice_lo(w, DATA_WIDTH) +: DATA_WIDTH];
            write_eff[w] = bus.write_en[w] && !busy &&
                           !((ZERO_REG_EN != 0) && (wr_sel[w] == '0));
        end
    end

    // Any pair of effective ports aiming at the same register is a conflict.
    always_comb begin
        conflict_now = 1'b0;
        for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
            for (int j = i + 1; j < NUM_WRITE_PORTS; j++) begin
                if (write_eff[i] && write_eff[j] && (wr_sel[i] == wr_sel[j])) begin
                    conflict_now = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_conflict_q <= 1'b0;
        end else begin
            write_conflict_q <= conflict_now;
        end
    end

    // Storage has no reset; the clear engine zeroes it one entry per cycle.
    // Ports are scanned in ascending order so the highest-indexed effective
    // port's write is the last assignment and therefore wins.
    always_ff @(posedge clk) begin
        if (clear_we) begin
            regs[clear_idx] <= '0;
        end else begin
            for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
                if (write_eff[w]) begin
                    regs[wr_sel[w]] <= wr_data[w];
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_read
        logic [SEL_WIDTH-1:0]  rd_sel;
        logic [DATA_WIDTH-1:0] rd_value;

        // Bypass scans ascending so the highest-indexed matching port wins;
        // the busy / zero-register gate is applied last so it overrides both.
        always_comb begin
            rd_sel   = bus.read_sel[slice_lo(p, SEL_WIDTH) +: SEL_WIDTH];
            rd_value = regs[rd_sel];
            if (BYPASS_EN != 0) begin
                for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
                    if (write_eff[w] && (wr_sel[w] == rd_sel)) begin
                        rd_value = wr_data[w];
                    end
                end
            end
            if (busy || ((ZERO_REG_EN != 0) && (rd_sel == '0))) begin
                rd_value = '0;
            end
        end

        assign bus.read_data[slice_lo(p, DATA_WIDTH) +: DATA_WIDTH] = rd_value;
    end

    assign bus.busy           = busy;
    assign bus.write_conflict = write_conflict_q;

endmodule

// File: tb/tb_register_file_multiport.sv
// ---------------------------------------------------------------------------
// tb_register_file_multiport
// Drives two register files with identical stimulus: dut_a has the zero
// register and bypass enabled, dut_b has both disabled. Each cycle the
// outputs are compared against a behavioural model of register contents,
// clear progress and write conflicts.
// ---------------------------------------------------------------------------
module tb_register_file_multiport;

    localparam int DW  = 32;
    localparam int NR  = 16;
    localparam int NRP = 2;
    localparam int NWP = 2;
    localparam int SW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic [SW-1:0]  rsel  [NRP];
    logic [NWP-1:0] wen;
    logic [SW-1:0]  wsel  [NWP];
    logic [DW-1:0]  wdata [NWP];
    logic           creq;

    register_file_multiport_if #(.DATA_WIDTH(DW), .NUM_REGS(NR),
        .NUM_READ_PORTS(NRP), .NUM_WRITE_PORTS(NWP)) bus_a ();
    register_file_multiport_if #(.DATA_WIDTH(DW), .NUM_REGS(NR),
        .NUM_READ_PORTS(NRP), .NUM_WRITE_PORTS(NWP)) bus_b ();

    assign bus_a.read_sel   = {rsel[1], rsel[0]};
    assign bus_a.write_en   = wen;
    assign bus_a.write_sel  = {wsel[1], wsel[0]};
    assign bus_a.write_data = {wdata[1], wdata[0]};
    assign bus_a.clear_req  = creq;
    assign bus_b.read_sel   = {rsel[1], rsel[0]};
    assign bus_b.write_en   = wen;
    assign bus_b.write_sel  = {wsel[1], wsel[0]};
    assign bus_b.write_data = {wdata[1], wdata[0]};
    assign bus_b.clear_req  = creq;

    register_file_multiport #(.DATA_WIDTH(DW), .NUM_REGS(NR),
        .NUM_READ_PORTS(NRP), .NUM_WRITE_PORTS(NWP),
        .ZERO_REG_EN(1), .BYPASS_EN(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    register_file_multiport #(.DATA_WIDTH(DW), .NUM_REGS(NR),
        .NUM_READ_PORTS(NRP), .NUM_WRITE_PORTS(NWP),
        .ZERO_REG_EN(0), .BYPASS_EN(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    // Reference state: cfg 0 mirrors dut_a, cfg 1 mirrors dut_b.
    logic [DW-1:0] mem [2][NR];
    int            clear_left;
    logic          exp_conf [2];

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs,
                               input logic [DW-1:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic bit zeroEn(input int cfg);
        return (cfg == 0);
    endfunction

    function automatic bit bypassEn(input int cfg);
        return (cfg == 0);
    endfunction

    function automatic bit isEffective(input int cfg, input int w);
        return (clear_left == 0) && wen[w] && !(zeroEn(cfg) && wsel[w] == 0);
    endfunction

    function automatic logic [DW-1:0] expectRead(input int cfg, input int p);
        logic [DW-1:0] v;
        if (clear_left != 0) return '0;
        if (zeroEn(cfg) && rsel[p] == 0) return '0;
        v = mem[cfg][rsel[p]];
        if (bypassEn(cfg)) begin
            for (int w = 0; w < NWP; w++) begin
                if (isEffective(cfg, w) && wsel[w] == rsel[p]) v = wdata[w];
            end
        end
        return v;
    endfunction

    function automatic logic [DW-1:0] observedRead(input int cfg, input int p);
        return (cfg == 0) ? bus_a.read_data[p*DW +: DW] : bus_b.read_data[p*DW +: DW];
    endfunction

    // Advance the reference by one rising edge using the inputs of this cycle.
    task automatic modelEdge();
        bit cflag [2];
        for (int cfg = 0; cfg < 2; cfg++) begin
            cflag[cfg] = 1'b0;
            for (int i = 0; i < NWP; i++)
                for (int j = i + 1; j < NWP; j++)
                    if (isEffective(cfg, i) && isEffective(cfg, j) && wsel[i] == wsel[j])
                        cflag[cfg] = 1'b1;
            for (int w = 0; w < NWP; w++)
                if (isEffective(cfg, w)) mem[cfg][wsel[w]] = wdata[w];
        end
        exp_conf[0] = cflag[0];
        exp_conf[1] = cflag[1];
        if (clear_left > 0) begin
            clear_left--;
            if (clear_left == 0) begin
                for (int cfg = 0; cfg < 2; cfg++)
                    for (int r = 0; r < NR; r++) mem[cfg][r] = '0;
            end
        end else if (creq) begin
            clear_left = NR;
        end
    endtask

    // One clock cycle with the currently driven inputs: check every output,
    // take the rising edge, update the reference, return at the falling edge.
    task automatic applyStimulus();
        #2;
        for (int cfg = 0; cfg < 2; cfg++) begin
            for (int p = 0; p < NRP; p++)
                checkOutput($sformatf("cfg%0d_rd%0d_sel%0d", cfg, p, rsel[p]),
                            observedRead(cfg, p), expectRead(cfg, p));
        end
        checkOutput("busy_a", DW'(bus_a.busy), DW'(clear_left != 0));
        checkOutput("busy_b", DW'(bus_b.busy), DW'(clear_left != 0));
        checkOutput("conflict_a", DW'(bus_a.write_conflict), DW'(exp_conf[0]));
        checkOutput("conflict_b", DW'(bus_b.write_conflict), DW'(exp_conf[1]));
        @(posedge clk);
        if (!rst) modelEdge();
        @(negedge clk);
    endtask

    task automatic idleInputs();
        wen  = '0;
        creq = 1'b0;
    endtask

    task automatic randomStim(input bit allow_clear);
        for (int p = 0; p < NRP; p++) rsel[p] = SW'($urandom_range(0, NR - 1));
        wen      = NWP'($urandom);
        wsel[0]  = SW'($urandom_range(0, NR - 1));
        wsel[1]  = ($urandom_range(0, 3) == 0) ? wsel[0] : SW'($urandom_range(0, NR - 1));
        wdata[0] = $urandom;
        wdata[1] = $urandom;
        creq     = allow_clear && ($urandom_range(0, 39) == 0);
    endtask

    task automatic doReset(input int hold);
        rst         = 1'b1;
        clear_left  = NR;
        exp_conf[0] = 1'b0;
        exp_conf[1] = 1'b0;
        idleInputs();
        repeat (hold) applyStimulus();
        rst = 1'b0;
    endtask

    // Count cycles with busy high; a runaway clear stops at the bound.
    task automatic countBusy(input string tag, input bit rand_writes);
        int n = 0;
        while (bus_a.busy === 1'b1 && n < 40) begin
            if (rand_writes) randomStim(1'b0);
            n++;
            applyStimulus();
        end
        idleInputs();
        checkOutput(tag, DW'(n), DW'(NR));
    endtask

    task automatic readAll();
        idleInputs();
        for (int r = 0; r < NR; r++) begin
            rsel[0] = SW'(r);
            rsel[1] = SW'(NR - 1 - r);
            applyStimulus();
        end
    endtask

    initial begin
        for (int p = 0; p < NRP; p++) rsel[p] = '0;
        for (int w = 0; w < NWP; w++) begin
            wsel[w]  = '0;
            wdata[w] = '0;
        end
        idleInputs();
        for (int cfg = 0; cfg < 2; cfg++)
            for (int r = 0; r < NR; r++) mem[cfg][r] = '0;

        $display("[TB] reset and initial clear");
        doReset(2);
        countBusy("clear_len_reset", 1'b0);
        readAll();

        $display("[TB] bypass write r5");
        rsel[0] = 4'd5; rsel[1] = 4'd5;
        wen = 2'b01; wsel[0] = 4'd5; wdata[0] = 32'hDEADBEEF;
        applyStimulus();
        idleInputs();
        applyStimulus();

        $display("[TB] write to r0");
        rsel[0] = 4'd0;
        wen = 2'b01; wsel[0] = 4'd0; wdata[0] = 32'h0000_1234;
        applyStimulus();
        idleInputs();
        applyStimulus();

        $display("[TB] same-target write on r3");
        rsel[0] = 4'd3;
        wen = 2'b11; wsel[0] = 4'd3; wsel[1] = 4'd3;
        wdata[0] = 32'h0000_AAAA; wdata[1] = 32'h0000_5555;
        applyStimulus();
        idleInputs();
        applyStimulus();
        checkOutput("r3_winner", observedRead(1, 0), 32'h0000_5555);
        applyStimulus();

        $display("[TB] fill and clear request");
        for (int r = 1; r < NR; r++) begin
            wen = 2'b01; wsel[0] = SW'(r); wdata[0] = DW'(r);
            rsel[0] = SW'(r - 1);
            applyStimulus();
        end
        idleInputs();
        readAll();
        creq = 1'b1;
        applyStimulus();
        creq = 1'b0;
        countBusy("clear_len_request", 1'b1);
        readAll();

        $display("[TB] reset in the middle of a clear");
        creq = 1'b1;
        applyStimulus();
        creq = 1'b0;
        repeat (7) applyStimulus();
        doReset(1);
        countBusy("clear_len_restart", 1'b0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            randomStim(1'b1);
            applyStimulus();
        end
        idleInputs();
        readAll();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
